// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - tick-paced FSM stepping an external ALU through ADD/SUB/AND/OR/XOR
module alu_sequencer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_REPEAT = 1'b0
) (
    input  logic             clock50Mhz,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             hold,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [WIDTH-1:0] AluOut,
    input  logic             AluCarry,
    output logic [WIDTH-1:0] OpA,
    output logic [WIDTH-1:0] OpB,
    output logic [2:0]       AluOp,
    output logic [WIDTH-1:0] Result,
    output logic             ResultCarry,
    output logic [2:0]       PrState,
    output logic [2:0]       NxState,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LOAD  = 3'b001,
        S_ADD = 3'b010,
        S_SUB = 3'b011,
        S_AND = 3'b100,
        S_OR  = 3'b101,
        S_XOR = 3'b110,
        DONE  = 3'b111
    } state_t;

    state_t state;
    state_t next_state;
    logic   adv;
    logic   in_op_state;

    assign adv         = tick & ~hold;
    assign in_op_state = (state >= S_ADD) && (state <= S_XOR);

    // next_state is where an advance would go; hold only masks what NxState shows
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? LOAD : IDLE;
            LOAD:    next_state = S_ADD;
            S_ADD:   next_state = S_SUB;
            S_SUB:   next_state = S_AND;
            S_AND:   next_state = S_OR;
            S_OR:    next_state = S_XOR;
            S_XOR:   next_state = DONE;
            DONE:    next_state = (AUTO_REPEAT && start) ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        AluOp = 3'b000;
        case (state)
            S_ADD:   AluOp = 3'b000;
            S_SUB:   AluOp = 3'b001;
            S_AND:   AluOp = 3'b010;
            S_OR:    AluOp = 3'b011;
            S_XOR:   AluOp = 3'b100;
            default: AluOp = 3'b000;
        endcase
    end

    assign PrState = state;
    assign NxState = hold ? state : next_state;

    always_ff @(posedge clock50Mhz) begin
        if (reset) begin
            state       <= IDLE;
            OpA         <= '0;
            OpB         <= '0;
            Result      <= '0;
            ResultCarry <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (adv) begin
                state <= next_state;
                Busy  <= (next_state != IDLE);
                Done  <= (next_state == DONE);
                if (state == LOAD) begin
                    OpA <= InputA;
                    OpB <= InputB;
                end
                // each run starts with a clean result, whether from IDLE or auto-repeat
                if (next_state == LOAD) begin
                    Result      <= '0;
                    ResultCarry <= 1'b0;
                end else if (in_op_state) begin
                    Result      <= AluOut;
                    ResultCarry <= AluCarry;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed vector bench for alu_sequencer, normal and auto-repeat builds
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset, tick, start, hold;
    logic [3:0] ina, inb;

    logic [3:0] opa1, opb1, res1, aluout1;
    logic [2:0] aluop1, pr1, nx1;
    logic       cy1, alucy1, busy1, done1;

    logic [3:0] opa2, opb2, res2, aluout2;
    logic [2:0] aluop2, pr2, nx2;
    logic       cy2, alucy2, busy2, done2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [3:0] d;
        d = a - b;
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {(a < b) ? 1'b1 : 1'b0, d};
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a | b};
            3'b100:  return {1'b0, a ^ b};
            default: return 5'b0;
        endcase
    endfunction

    assign {alucy1, aluout1} = alu(opa1, opb1, aluop1);
    assign {alucy2, aluout2} = alu(opa2, opb2, aluop2);

    alu_sequencer #(.WIDTH(4), .AUTO_REPEAT(1'b0)) dut1 (
        .clock50Mhz(clk), .reset(reset), .tick(tick), .start(start), .hold(hold),
        .InputA(ina), .InputB(inb), .AluOut(aluout1), .AluCarry(alucy1),
        .OpA(opa1), .OpB(opb1), .AluOp(aluop1), .Result(res1), .ResultCarry(cy1),
        .PrState(pr1), .NxState(nx1), .Busy(busy1), .Done(done1)
    );

    alu_sequencer #(.WIDTH(4), .AUTO_REPEAT(1'b1)) dut2 (
        .clock50Mhz(clk), .reset(reset), .tick(tick), .start(start), .hold(hold),
        .InputA(ina), .InputB(inb), .AluOut(aluout2), .AluCarry(alucy2),
        .OpA(opa2), .OpB(opb2), .AluOp(aluop2), .Result(res2), .ResultCarry(cy2),
        .PrState(pr2), .NxState(nx2), .Busy(busy2), .Done(done2)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       start;
        logic       hold;
        logic [2:0] st;
        logic [3:0] res;
        logic       cy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic s,
                                input logic h, input logic [2:0] st, input logic [3:0] res,
                                input logic cy);
        vec_t v;
        v.a = a; v.b = b; v.start = s; v.hold = h; v.st = st; v.res = res; v.cy = cy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; hold = 1'b0; ina = '0; inb = '0;

        // hold+tick in IDLE with start high must not move
        vecs.push_back(mk(4'd0, 4'd0, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0));
        // A=5 B=3
        vecs.push_back(mk(4'd5, 4'd3, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0));
        vecs.push_back(mk(4'd5, 4'd3, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0));
        vecs.push_back(mk(4'd5, 4'd3, 1'b0, 1'b0, 3'd3, 4'd8, 1'b0));
        vecs.push_back(mk(4'd5, 4'd3, 1'b0, 1'b0, 3'd4, 4'd2, 1'b0));
        vecs.push_back(mk(4'd5, 4'd3, 1'b0, 1'b0, 3'd5, 4'd1, 1'b0));
        vecs.push_back(mk(4'd5, 4'd3, 1'b0, 1'b0, 3'd6, 4'd7, 1'b0));
        vecs.push_back(mk(4'd5, 4'd3, 1'b0, 1'b0, 3'd7, 4'd6, 1'b0));
        vecs.push_back(mk(4'd5, 4'd3, 1'b0, 1'b0, 3'd0, 4'd6, 1'b0));
        // A=12 B=7: ADD overflows
        vecs.push_back(mk(4'd12, 4'd7, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0));
        vecs.push_back(mk(4'd12, 4'd7, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0));
        vecs.push_back(mk(4'd12, 4'd7, 1'b0, 1'b0, 3'd3, 4'd3, 1'b1));
        vecs.push_back(mk(4'd12, 4'd7, 1'b0, 1'b0, 3'd4, 4'd5, 1'b0));
        vecs.push_back(mk(4'd12, 4'd7, 1'b0, 1'b0, 3'd5, 4'd4, 1'b0));
        vecs.push_back(mk(4'd12, 4'd7, 1'b0, 1'b0, 3'd6, 4'd15, 1'b0));
        vecs.push_back(mk(4'd12, 4'd7, 1'b0, 1'b0, 3'd7, 4'd11, 1'b0));
        vecs.push_back(mk(4'd12, 4'd7, 1'b0, 1'b0, 3'd0, 4'd11, 1'b0));
        // A=3 B=9: SUB borrows
        vecs.push_back(mk(4'd3, 4'd9, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0));
        vecs.push_back(mk(4'd3, 4'd9, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0));
        vecs.push_back(mk(4'd3, 4'd9, 1'b0, 1'b0, 3'd3, 4'd12, 1'b0));
        vecs.push_back(mk(4'd3, 4'd9, 1'b0, 1'b0, 3'd4, 4'd10, 1'b1));
        vecs.push_back(mk(4'd3, 4'd9, 1'b0, 1'b0, 3'd5, 4'd1, 1'b0));
        vecs.push_back(mk(4'd3, 4'd9, 1'b0, 1'b0, 3'd6, 4'd11, 1'b0));
        vecs.push_back(mk(4'd3, 4'd9, 1'b0, 1'b0, 3'd7, 4'd10, 1'b0));
        vecs.push_back(mk(4'd3, 4'd9, 1'b0, 1'b0, 3'd0, 4'd10, 1'b0));

        repeat (2) @(negedge clk);
        check("rst_state", pr1, 3'd0);
        check("rst_result", res1, 4'd0);
        check("rst_opa", opa1, 4'd0);
        check("rst_done", done1, 1'b0);
        reset = 1'b0;
        repeat (5) pulse();
        check("idle_state", pr1, 3'd0);
        check("idle_busy", busy1, 1'b0);
        check("idle_result", res1, 4'd0);
        check("idle_aluop", aluop1, 3'd0);
        check("idle_nx", nx1, 3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ina = vecs[i].a; inb = vecs[i].b; start = vecs[i].start; hold = vecs[i].hold;
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            check($sformatf("v%0d_state", i), pr1, vecs[i].st);
            check($sformatf("v%0d_result", i), res1, vecs[i].res);
            check($sformatf("v%0d_carry", i), cy1, vecs[i].cy);
            check($sformatf("v%0d_busy", i), busy1, vecs[i].st != 3'd0);
            check($sformatf("v%0d_done", i), done1, vecs[i].st == 3'd7);
            hold = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_done_off", i), done1, 1'b0);
            check($sformatf("v%0d_state_hold", i), pr1, vecs[i].st);
        end

        // operand latching, hold in S_AND, mid-run reset
        ina = 4'd5; inb = 4'd3; start = 1'b1;
        pulse();
        start = 1'b0;
        pulse();
        check("lat_opa", opa1, 4'd5);
        ina = 4'd15;
        pulse();
        check("lat_opa_after", opa1, 4'd5);
        check("lat_add", res1, 4'd8);
        pulse();
        check("at_and", pr1, 3'd4);
        check("and_aluop", aluop1, 3'b010);
        hold = 1'b1;
        repeat (3) pulse();
        check("hold_state", pr1, 3'd4);
        check("hold_result", res1, 4'd2);
        check("hold_nx", nx1, 3'd4);
        @(negedge clk);
        hold = 1'b0;
        #1;
        check("release_nx", nx1, 3'd5);
        pulse();
        check("resume_state", pr1, 3'd5);
        check("resume_result", res1, 4'd1);
        check("or_aluop", aluop1, 3'b011);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_state", pr1, 3'd0);
        check("mrst_result", res1, 4'd0);
        check("mrst_opa", opa1, 4'd0);
        check("mrst_done", done1, 1'b0);
        check("mrst_busy", busy1, 1'b0);
        @(negedge clk);
        check("mrst_done2", done1, 1'b0);

        // auto-repeat: DONE with start high re-enters LOAD in dut2 only
        ina = 4'd5; inb = 4'd3; start = 1'b1;
        repeat (7) pulse();
        check("ar_done_state", pr2, 3'd7);
        check("ar_done_pulse", done2, 1'b1);
        check("ar_res_xor", res2, 4'd6);
        check("ar_nx2", nx2, 3'd1);
        check("ar_nx1", nx1, 3'd0);
        ina = 4'd12; inb = 4'd7;
        pulse();
        check("ar_load_state", pr2, 3'd1);
        check("ar_load_clear", res2, 4'd0);
        check("ar_load_cy", cy2, 1'b0);
        check("ar_norep_state", pr1, 3'd0);
        check("ar_norep_res", res1, 4'd6);
        pulse();
        check("ar_opa", opa2, 4'd12);
        check("ar_opb", opb2, 4'd7);
        pulse();
        check("ar_add", res2, 4'd3);
        check("ar_add_cy", cy2, 1'b1);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- FSM controller that steps the 4-bit ALU through a fixed operation program: ADD, SUB, AND, OR, XOR.
- Operands A/B are latched once per run; each ALU result is captured into a result register.
- Advances only on the 1 Hz enable pulse from the clock divider, so each step is visible on the state LEDs and 7-segment displays.
- Sits between the divider/input switches and the ALU, and drives the PrState/NxState LEDs.

Parameters:
WIDTH, 4, operand/result width
AUTO_REPEAT, 0, 1 = DONE returns to LOAD (not IDLE) when start is high at the leaving tick

Ports:
clock50Mhz  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high
tick  in  1  one-cycle enable pulse (1 Hz) from divider
start  in  1  level; begins a run when sampled high on a tick in IDLE
hold  in  1  level; freezes the FSM while high
InputA  in  WIDTH  operand A source (switches)
InputB  in  WIDTH  operand B source (switches)
AluOut  in  WIDTH  combinational ALU result for OpA/OpB/AluOp
AluCarry  in  1  ALU carry-out (ADD) / borrow (SUB); 0 for logic ops
OpA  out  WIDTH  latched operand A to ALU
OpB  out  WIDTH  latched operand B to ALU
AluOp  out  3  ALU opcode: ADD=000 SUB=001 AND=010 OR=011 XOR=100
Result  out  WIDTH  last captured ALU result
ResultCarry  out  1  carry captured with Result
PrState  out  3  present state code
NxState  out  3  next state code
Busy  out  1  high in every state except IDLE
Done  out  1  one-clock pulse at run completion

Behaviour:
- State codes: IDLE=000, LOAD=001, S_ADD=010, S_SUB=011, S_AND=100, S_OR=101, S_XOR=110, DONE=111.
- Reset (synchronous, overrides everything incl. tick):
  - state=IDLE; OpA=OpB=0; Result=0; ResultCarry=0; Done=0.
  - AluOp=000; PrState=000; NxState=000 or 001 depending on start (combinational, see below).
- Advance condition: adv = tick & ~hold. Without adv, all registers hold. hold wins over a simultaneous tick.
- Transitions, taken only on adv:
  - IDLE -> LOAD if start=1, else stay in IDLE. Entering LOAD clears Result and ResultCarry to 0.
  - LOAD -> S_ADD; OpA<=InputA and OpB<=InputB on this edge.
  - S_ADD -> S_SUB -> S_AND -> S_OR -> S_XOR -> DONE.
  - In each op state, the adv edge also does Result<=AluOut and ResultCarry<=AluCarry.
  - DONE -> IDLE, or DONE -> LOAD if AUTO_REPEAT=1 and start=1.
- start is ignored outside IDLE (and outside DONE when AUTO_REPEAT=1).
- OpA/OpB are stable from S_ADD through DONE; input changes after LOAD have no effect.
- AluOp is a combinational decode of state: op code in the op states, 000 in IDLE/LOAD/DONE.
- PrState equals the state register.
- NxState is combinational: the state that would be entered if adv occurred now. If hold=1, NxState=PrState.
- Done: registered; 1 for exactly one clock50Mhz cycle, the cycle after the edge entering DONE.
- Busy: registered from state; 1 in any state except IDLE.
- Latency: 7 ticks from the IDLE tick that samples start to DONE.
- Result truncates to WIDTH bits; overflow is reported only via ResultCarry.
- Reset asserted mid-run (any state) returns to IDLE on that edge; there is no partial-result retention.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then 5 ticks with start=0 -> PrState=000, Busy=0, Result=0, AluOp=000, NxState=000.
- Basic run, A=5, B=3, start=1 -> after each op tick Result is 8(c0), 2(c0), 1, 7, 6. States are 001..111. Done pulses for exactly 1 cycle. Next tick returns to IDLE.
- Overflow/borrow, A=12, B=7, then A=3, B=9:
  - A=12, B=7 -> ADD Result=3 with ResultCarry=1.
  - A=3, B=9 -> SUB Result=10 with ResultCarry=1.
- Input change and hold:
  - InputA changed to 15 after LOAD -> OpA stays 5.
  - hold=1 across 3 ticks in S_AND -> state, Result and NxState=100 frozen; run resumes on release.
- Tick/hold coincidence and mid-run reset:
  - tick coincident with hold -> no advance.
  - reset pulse in S_OR -> next edge PrState=000, Result=0, OpA=0, with no Done pulse.
- AUTO_REPEAT=1 with start held high -> DONE goes to LOAD (001). Result is cleared and the new operands are latched.
